mux8_serializer: RTL and testbench

Sequencer that feeds an 8:1 bit mux and consumes its output to transmit a byte as a framed serial stream. It accepts a byte on a valid/ready handshake and holds it on the mux data inputs. It steps the mux select 0..7, LSB first, once per bit period. It wraps the mux output with a start bit (0) and a stop bit (1) on a registered serial line. It sits directly upstream of the `mux8` instance: `d[i]` drives mux input `d<i>`, `sel` drives `sel`, and the mux output returns on `y`.

---
 rtl/mux8_pkg.sv | 5 +
 rtl/mux8_serializer_bit_timer.sv | 20 ++
 rtl/mux8_serializer.sv | 84 ++++++++
 tb/tb_mux8_serializer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mux8_pkg.sv
// mux8_pkg: shared FSM state type and select limit for the mux8 serializer
package mux8_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} ser_state_t;
  localparam logic [2:0] SEL_LAST = 3'd7;
endpackage

// File: rtl/mux8_serializer_bit_timer.sv
// bit_timer: bit-period counter; tick marks the last clock of each DIV-clock period
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (held while idle so every period starts at 0)
//   tick     : high when the count reaches DIV-1
module bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q;
  assign tick = cnt_q == W'(DIV - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= (clr || tick) ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/mux8_serializer.sv
// mux8_serializer: drives an external 8:1 mux and frames its output as a serial byte
//   din/valid/ready : byte handshake, accepted only in IDLE
//   d/sel           : held byte and bit select toward the mux
//   y               : mux output, consumed combinationally
//   txd             : registered serial line (start 0, 8 data LSB first, stop 1)
//   busy/done       : not-IDLE flag, one-cycle frame-complete pulse
module mux8_serializer
  import mux8_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] d,
  output logic [2:0] sel,
  input  logic       y,
  output logic       txd,
  output logic       busy,
  output logic       done
);
  ser_state_t state_q, state_d;
  logic [7:0] d_q, d_d;
  logic [2:0] sel_q, sel_d;
  logic       txd_q, txd_d, done_q, done_d, tick, idle;
  assign idle = state_q == IDLE;
  // Holding the timer clear in IDLE restarts the period exactly at capture.
  bit_timer #(.DIV(DIV)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (idle),
    .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (valid) begin
        d_d     = din;
        sel_d   = '0;
        state_d = START;
      end
      START: if (tick) begin
        sel_d   = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        sel_d   = sel_q == SEL_LAST ? '0 : sel_q + 3'd1;
        state_d = sel_q == SEL_LAST ? STOP : DATA;
      end
      STOP: if (tick) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    txd_d = state_q == DATA ? y : state_q != START;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      sel_q   <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      sel_q   <= sel_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end
  assign ready = idle;
  assign busy  = !idle;
  assign d     = d_q;
  assign sel   = sel_q;
  assign txd   = txd_q;
  assign done  = done_q;
endmodule

// File: tb/tb_mux8_serializer.sv
// tb_mux8_serializer: scoreboard bench for DIV=4 (unit 0) and DIV=1 (unit 1)
module tb_mux8_serializer;
  typedef struct {
    logic [7:0] b;
    logic [9:0] f;
    int         gap;
  } fr_t;
  logic       clk = 1'b0;
  logic       rst [2];
  logic       valid [2];
  logic       ready [2];
  logic       y [2];
  logic       txd [2];
  logic       busy [2];
  logic       done [2];
  logic [7:0] din [2];
  logic [7:0] d [2];
  logic [2:0] sel [2];
  fr_t        q0[$], q1[$];
  int         cmp = 0, err = 0, cyc = 0;
  logic       fin = 1'b0, fin_done = 1'b0;
  always #5 clk = ~clk;
  mux8_serializer #(.DIV(4)) dut0 (
    .clk(clk), .rst(rst[0]), .din(din[0]), .valid(valid[0]), .ready(ready[0]),
    .d(d[0]), .sel(sel[0]), .y(y[0]), .txd(txd[0]), .busy(busy[0]), .done(done[0])
  );
  mux8_serializer #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst[1]), .din(din[1]), .valid(valid[1]), .ready(ready[1]),
    .d(d[1]), .sel(sel[1]), .y(y[1]), .txd(txd[1]), .busy(busy[1]), .done(done[1])
  );
  assign y[0] = d[0][sel[0]];
  assign y[1] = d[1][sel[1]];
  function automatic int qsize(int u);
    return u == 0 ? q0.size() : q1.size();
  endfunction
  function automatic fr_t qpop(int u);
    return u == 0 ? q0.pop_front() : q1.pop_front();
  endfunction
  task automatic qpush(int u, fr_t e);
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  // Monitor: detects each start bit, pops the expected frame and checks every sample.
  logic active [2] = '{1'b0, 1'b0};
  logic prev_y [2] = '{1'b0, 1'b0};
  int   j [2] = '{0, 0};
  int   last_s [2] = '{0, 0};
  int   done_cnt [2] = '{0, 0};
  fr_t  cur [2];
  task automatic chk(input int u, input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      err++;
      $display("FAIL u%0d %s at cyc %0d: got %0h expected %0h", u, nm, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    for (int u = 0; u < 2; u++) begin
      int dv, k;
      dv = u == 0 ? 4 : 1;
      if (rst[u]) begin
        chk(u, "reset_state", {26'd0, txd[u], busy[u], ready[u], done[u], sel[u] == 3'd0, d[u] == 8'd0},
            {26'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
        active[u] = 1'b0;
      end else begin
        if (done[u]) done_cnt[u]++;
        if (!active[u] && txd[u] == 1'b0) begin
          chk(u, "frame_expected", qsize(u) > 0, 1);
          if (qsize(u) > 0) begin
            cur[u] = qpop(u);
            if (cur[u].gap != 0) chk(u, "capture_gap", cyc - last_s[u], cur[u].gap);
            last_s[u] = cyc;
            active[u] = 1'b1;
            j[u] = 0;
          end
        end
        if (active[u]) begin
          k = j[u] / dv;
          chk(u, $sformatf("txd_bit%0d", k), txd[u], cur[u].f[k]);
          chk(u, "d_held", d[u], cur[u].b);
          chk(u, "busy", busy[u], j[u] != 10 * dv - 1);
          chk(u, "done", done[u], j[u] == 10 * dv - 1);
          if (j[u] == 10 * dv - 1) chk(u, "ready_at_done", ready[u], 1);
          if (j[u] + 1 >= dv && j[u] + 1 < 9 * dv) chk(u, "sel", sel[u], (j[u] + 1) / dv - 1);
          if (k >= 1 && k <= 8) chk(u, "txd_follows_y", txd[u], prev_y[u]);
          j[u]++;
          if (j[u] == 10 * dv) active[u] = 1'b0;
        end
      end
      prev_y[u] = y[u];
    end
    if (fin && !fin_done) begin
      chk(0, "done_pulses", done_cnt[0], 4);
      chk(1, "done_pulses", done_cnt[1], 1);
      chk(0, "queue_left", qsize(0), 0);
      chk(1, "queue_left", qsize(1), 0);
      fin_done = 1'b1;
    end
  end
  task automatic send(input int u, input logic [7:0] b, input logic [9:0] f, input int gap, input bit hold);
    fr_t e;
    e.b = b; e.f = f; e.gap = gap;
    din[u] = b;
    valid[u] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready[u]) begin
        qpush(u, e);
        @(posedge clk);
        #1;
        if (!hold) valid[u] = 1'b0;
        return;
      end
    end
    $display("FAIL u%0d send_timeout byte %0h", u, b);
    $fatal(1);
  endtask
  task automatic wait_idle(input int u);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (ready[u]) begin
        repeat (2) @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL u%0d idle_timeout", u);
    $fatal(1);
  endtask
  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; valid[u] = 1'b0; din[u] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(0, 8'hA5, 10'b1101001010, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    din[0] = 8'h5A; valid[0] = 1'b1;
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    wait_idle(0);
    send(0, 8'h00, 10'b1000000000, 0, 1'b1);
    send(0, 8'hFF, 10'b1111111110, 41, 1'b0);
    wait_idle(0);
    send(0, 8'hA5, 10'b1101001010, 0, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    rst[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    send(0, 8'h3C, 10'b1001111000, 0, 1'b0);
    wait_idle(0);
    send(1, 8'h81, 10'b1100000010, 0, 1'b0);
    wait_idle(1);
    fin = 1'b1;
    for (int t = 0; t < 10 && !fin_done; t++) @(posedge clk);
    if (!fin_done) begin
      $display("FAIL final_check_timeout");
      $fatal(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
